// File: rtl/mips_instr_encoder.sv
// MIPS-I instruction word assembler feeding instruction memory through a small FIFO.
// Optional opcode/format checking is enabled by defining ENC_OPCHECK_EN.
module mips_instr_encoder #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enc_valid_i,
    output logic              enc_ready_o,
    input  logic [1:0]        enc_fmt_i,
    input  logic [5:0]        enc_op_i,
    input  logic [5:0]        enc_funct_i,
    input  logic [4:0]        enc_rs_i,
    input  logic [4:0]        enc_rt_i,
    input  logic [4:0]        enc_rd_i,
    input  logic [4:0]        enc_shamt_i,
    input  logic [15:0]       enc_imm_i,
    input  logic [25:0]       enc_target_i,
    input  logic              base_load_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    output logic              imem_wr_en_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    input  logic              imem_ready_i,
    output logic [15:0]       words_o,
    output logic              err_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [31:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [PTR_W:0]    count_next;
    logic              ready_reg;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       words;
    logic [5:0]        r_op;
    logic [31:0]       packed_word;
    logic              accept;
    logic              push;
    logic              pop;
    logic              empty;

    assign empty  = (count == '0);
    assign accept = enc_valid_i && ready_reg;
    assign pop    = !empty && imem_ready_i;

`ifdef ENC_OPCHECK_EN
    logic err_reg;

    // Reserved format completes its handshake but never reaches the FIFO.
    assign push  = accept && (enc_fmt_i != 2'd3);
    assign r_op  = 6'b000000;
    assign err_o = err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (accept && (enc_fmt_i == 2'd3)) begin
            err_reg <= 1'b1;
        end
    end
`else
    assign push  = accept;
    assign r_op  = enc_op_i;
    assign err_o = 1'b0;
`endif

    always_comb begin
        packed_word = '0;
        case (enc_fmt_i)
            2'd0:    packed_word = {r_op, enc_rs_i, enc_rt_i, enc_rd_i, enc_shamt_i, enc_funct_i};
            2'd1:    packed_word = {enc_op_i, enc_rs_i, enc_rt_i, enc_imm_i};
            default: packed_word = {enc_op_i, enc_target_i};
        endcase
    end

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= packed_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ready_reg <= 1'b0;
            addr      <= '0;
            words     <= '0;
        end else begin
            count     <= count_next;
            // Ready is derived from the next occupancy so it drops the cycle after filling.
            ready_reg <= (count_next != FULL_COUNT);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                words  <= words + 1'b1;
            end
            if (base_load_i) begin
                addr <= base_addr_i;
            end else if (pop) begin
                addr <= addr + 1'b1;
            end
        end
    end

    assign enc_ready_o  = ready_reg;
    assign imem_wr_en_o = !empty;
    assign imem_addr_o  = addr;
    assign imem_wdata_o = empty ? 32'h0 : fifo_mem[rd_ptr];
    assign words_o      = words;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder: a driver queues expected words, a negedge monitor checks writes.
module tb_mips_instr_encoder;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 10;
    localparam int          ADDR_SPAN = 1 << ADDR_W;

    typedef struct {
        int fmt;
        int op;
        int funct;
        int rs;
        int rt;
        int rd;
        int sh;
        int imm;
        int tgt;
    } instr_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enc_valid_i = 1'b0;
    logic              enc_ready_o;
    logic [1:0]        enc_fmt_i = '0;
    logic [5:0]        enc_op_i = '0;
    logic [5:0]        enc_funct_i = '0;
    logic [4:0]        enc_rs_i = '0;
    logic [4:0]        enc_rt_i = '0;
    logic [4:0]        enc_rd_i = '0;
    logic [4:0]        enc_shamt_i = '0;
    logic [15:0]       enc_imm_i = '0;
    logic [25:0]       enc_target_i = '0;
    logic              base_load_i = 1'b0;
    logic [ADDR_W-1:0] base_addr_i = '0;
    logic              imem_wr_en_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic [31:0]       imem_wdata_o;
    logic              imem_ready_i = 1'b0;
    logic [15:0]       words_o;
    logic              err_o;

    mips_instr_encoder #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enc_valid_i (enc_valid_i),
        .enc_ready_o (enc_ready_o),
        .enc_fmt_i   (enc_fmt_i),
        .enc_op_i    (enc_op_i),
        .enc_funct_i (enc_funct_i),
        .enc_rs_i    (enc_rs_i),
        .enc_rt_i    (enc_rt_i),
        .enc_rd_i    (enc_rd_i),
        .enc_shamt_i (enc_shamt_i),
        .enc_imm_i   (enc_imm_i),
        .enc_target_i(enc_target_i),
        .base_load_i (base_load_i),
        .base_addr_i (base_addr_i),
        .imem_wr_en_o(imem_wr_en_o),
        .imem_addr_o (imem_addr_o),
        .imem_wdata_o(imem_wdata_o),
        .imem_ready_i(imem_ready_i),
        .words_o     (words_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int     tests = 0;
    int     fails = 0;
    int     cyc = 0;
    int     model_addr = 0;
    int     model_words = 0;
    bit     model_err = 1'b0;
    bit     rand_on = 1'b0;
    longint exp_q[$];
    int     fire_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint actual, input longint expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference packing by field weights rather than bit concatenation.
    function automatic longint model_word(input instr_t in);
        longint op = in.op;
`ifdef ENC_OPCHECK_EN
        if (in.fmt == 0) op = 0;
`endif
        case (in.fmt)
            0: return op * 64'd67108864 + in.rs * 64'd2097152 + in.rt * 64'd65536
                      + in.rd * 64'd2048 + in.sh * 64'd64 + in.funct;
            1: return op * 64'd67108864 + in.rs * 64'd2097152 + in.rt * 64'd65536 + in.imm;
            default: return op * 64'd67108864 + in.tgt;
        endcase
    endfunction

    function automatic instr_t rand_instr();
        instr_t r;
        r.fmt   = $urandom_range(0, 3);
        r.op    = $urandom_range(0, 63);
        r.funct = $urandom_range(0, 63);
        r.rs    = $urandom_range(0, 31);
        r.rt    = $urandom_range(0, 31);
        r.rd    = $urandom_range(0, 31);
        r.sh    = $urandom_range(0, 31);
        r.imm   = $urandom_range(0, 65535);
        r.tgt   = $urandom_range(0, (1 << 26) - 1);
        return r;
    endfunction

    function automatic instr_t mk(input int fmt, input int op, input int funct, input int rs,
                                  input int rt, input int rd, input int sh, input int imm,
                                  input int tgt);
        instr_t r;
        r.fmt = fmt; r.op = op; r.funct = funct; r.rs = rs; r.rt = rt;
        r.rd = rd; r.sh = sh; r.imm = imm; r.tgt = tgt;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input instr_t in);
        enc_valid_i  = 1'b1;
        enc_fmt_i    = 2'(in.fmt);
        enc_op_i     = 6'(in.op);
        enc_funct_i  = 6'(in.funct);
        enc_rs_i     = 5'(in.rs);
        enc_rt_i     = 5'(in.rt);
        enc_rd_i     = 5'(in.rd);
        enc_shamt_i  = 5'(in.sh);
        enc_imm_i    = 16'(in.imm);
        enc_target_i = 26'(in.tgt);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (enc_ready_o) begin
`ifdef ENC_OPCHECK_EN
                if (in.fmt == 3) model_err = 1'b1;
                else exp_q.push_back(model_word(in));
`else
                exp_q.push_back(model_word(in));
`endif
                tick();
                enc_valid_i = 1'b0;
                return;
            end
        end
        check("send_timeout", 0, 1);
        enc_valid_i = 1'b0;
        tick();
    endtask

    task automatic drain();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !imem_wr_en_o) begin
                tick();
                return;
            end
        end
        check("drain_timeout", exp_q.size(), 0);
        tick();
    endtask

    // Monitor: every accepted memory write is compared against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            bit fire;
            fire = imem_wr_en_o && imem_ready_i;
            if (!imem_wr_en_o) check("idle_wdata", imem_wdata_o, 0);
            if (fire) begin
                if (exp_q.size() == 0) begin
                    check("stray_write", 1, 0);
                end else begin
                    check("wdata", imem_wdata_o, exp_q.pop_front());
                end
                check("waddr", imem_addr_o, model_addr);
                check("words", words_o, model_words);
                fire_cyc.push_back(cyc);
                model_words = (model_words + 1) % 65536;
            end
            if (base_load_i) model_addr = base_addr_i;
            else if (fire) model_addr = (model_addr + 1) % ADDR_SPAN;
        end
    end

    initial begin
        instr_t ins;
        #2;
        check("rst_ready", enc_ready_o, 0);
        check("rst_wr_en", imem_wr_en_o, 0);
        check("rst_addr", imem_addr_o, 0);
        check("rst_wdata", imem_wdata_o, 0);
        check("rst_words", words_o, 0);
        check("rst_err", err_o, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", enc_ready_o, 1);

        // Base load then one R-type add.
        imem_ready_i = 1'b1;
        base_load_i  = 1'b1;
        base_addr_i  = 10'h010;
        tick();
        base_load_i = 1'b0;
        send(mk(0, 0, 'h20, 1, 2, 3, 0, 0, 0));
        @(negedge clk);
        check("r_latency_en", imem_wr_en_o, 1);
        check("r_data_const", imem_wdata_o, 32'h00221820);
        check("r_addr_const", imem_addr_o, 10'h010);
        drain();
        check("r_words", words_o, 1);

        // I then J back-to-back, written on consecutive cycles.
        fire_cyc.delete();
        send(mk(1, 'h08, 0, 1, 2, 0, 0, 'hFFFF, 0));
        send(mk(2, 'h02, 0, 0, 0, 0, 0, 0, 'h100));
        drain();
        check("ij_write_count", fire_cyc.size(), 2);
        if (fire_cyc.size() == 2) check("ij_consecutive", fire_cyc[1] - fire_cyc[0], 1);

        // Fill with memory stalled, then hold a fifth push until space frees.
        imem_ready_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(rand_instr());
        @(negedge clk);
        check("full_ready_low", enc_ready_o, 0);
        tick();
        fork
            send(mk(1, 'h23, 0, 4, 5, 0, 0, 'h1234, 0));
            begin
                repeat (3) @(negedge clk);
                check("full_held", enc_ready_o, 0);
                @(posedge clk);
                #1;
                imem_ready_i = 1'b1;
            end
        join
        drain();

        // Address wrap at the top of the word-address space.
        base_load_i = 1'b1;
        base_addr_i = '1;
        tick();
        base_load_i = 1'b0;
        send(mk(2, 'h03, 0, 0, 0, 0, 0, 0, 'h3FFFFFF));
        send(mk(1, 'h0D, 0, 7, 8, 0, 0, 'h00FF, 0));
        drain();
        check("wrap_addr_now", imem_addr_o, 1);

        // Opcode forcing and reserved format.
        send(mk(0, 'h3F, 'h2A, 9, 10, 11, 3, 0, 0));
        send(mk(3, 'h15, 0, 0, 0, 0, 0, 0, 'h0ABCDEF));
        drain();
        check("err_flag", err_o, model_err);

        // Reset mid-stream with three words buffered.
        imem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) send(rand_instr());
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", imem_wr_en_o, 0);
        check("mid_rst_addr", imem_addr_o, 0);
        check("mid_rst_words", words_o, 0);
        check("mid_rst_err", err_o, 0);
        exp_q.delete();
        model_addr  = 0;
        model_words = 0;
        model_err   = 1'b0;
        tick();
        rst_n = 1'b1;
        imem_ready_i = 1'b1;
        repeat (8) tick();
        check("post_rst_ready", enc_ready_o, 1);
        check("post_rst_words", words_o, 0);

        // Randomized traffic with random memory stalls and occasional base loads.
        rand_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    send(rand_instr());
                    if ($urandom_range(0, 3) == 0) tick();
                end
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    imem_ready_i = ($urandom_range(0, 3) != 0);
                    base_load_i  = ($urandom_range(0, 31) == 0);
                    base_addr_i  = ADDR_W'($urandom);
                    tick();
                end
                base_load_i  = 1'b0;
                imem_ready_i = 1'b1;
            end
        join
        drain();
        check("final_words", words_o, model_words);
        check("final_err", err_o, model_err);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Assembles MIPS-I instruction words from opcode/funct and field inputs, the inverse of the control decoder's opcode/funct interpretation. Sits between the test/boot loader and instruction memory: a producer presents one instruction per valid/ready handshake, the block packs it into a 32-bit word, buffers it in a small FIFO and streams it into instruction memory at an auto-incrementing word address.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2
- ADDR_W, 10, instruction memory word-address width

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- enc_valid_i  in  1  producer presents an instruction
- enc_ready_o  out  1  block accepts it (registered)
- enc_fmt_i  in  2  0=R, 1=I, 2=J, 3=reserved
- enc_op_i  in  6  opcode field
- enc_funct_i  in  6  funct field (R only)
- enc_rs_i, enc_rt_i, enc_rd_i, enc_shamt_i  in  5 each  register/shift fields
- enc_imm_i  in  16  immediate (I only)
- enc_target_i  in  26  jump target (J only)
- base_load_i  in  1  load write address from base_addr_i
- base_addr_i  in  ADDR_W  new write address
- imem_wr_en_o  out  1  write request to instruction memory
- imem_addr_o  out  ADDR_W  word address of current write
- imem_wdata_o  out  32  encoded instruction
- imem_ready_i  in  1  memory accepts write this cycle
- words_o  out  16  count of words written to memory
- err_o  out  1  sticky rejected-instruction flag (ENC_OPCHECK_EN only, else tied 0)

## Operation
- Packing: R = {op, rs, rt, rd, shamt, funct}; I = {op, rs, rt, imm}; J = {op, target}. Unused field inputs ignored.
- Push: enc_valid_i && enc_ready_o at a rising edge writes the packed word at FIFO tail.
- enc_ready_o = !full, computed from registered occupancy; no bypass when full.
- Pop: imem_wr_en_o = !empty; head word and imem_addr_o are held stable until imem_wr_en_o && imem_ready_i, which pops the head, increments imem_addr_o by 1 (wraps 2^ADDR_W-1 -> 0) and increments words_o (wraps 0xFFFF -> 0).
- Simultaneous push and pop (not full, not empty): occupancy unchanged, both take effect.
- base_load_i: imem_addr_o <= base_addr_i next edge; if coincident with a pop, the popped word uses the old address and load wins over increment. FIFO contents unaffected.
- Reset (any time, including mid-stream): FIFO emptied, buffered words discarded, all counters and flags cleared.

## Timing
- Reset values: enc_ready_o=0, imem_wr_en_o=0, imem_addr_o=0, imem_wdata_o=0, words_o=0, err_o=0.
- enc_ready_o rises at first clock edge after rst_n deasserts.
- Latency: word accepted at edge N is on imem_wdata_o with imem_wr_en_o=1 after edge N (cycle N+1) if FIFO was empty.
- Throughput: one word per cycle sustained while imem_ready_i=1.
- Full: after DEPTH pushes with imem_ready_i=0, enc_ready_o=0 the next cycle; rises the cycle after the first pop.
- imem_wdata_o shows the FIFO head (0 when empty).

## Configuration
- ENC_OPCHECK_EN defined: R-format forces op field to 6'b000000 regardless of enc_op_i; fmt=3 is handshaken (enc_ready_o honoured) but not pushed, and sets err_o, which stays 1 until reset.
- Undefined: no checks; R uses enc_op_i as-is; fmt=3 packs as J; err_o constant 0.

## Test plan
- Reset, base_load 0x010, push R (op=0, rs=1, rt=2, rd=3, shamt=0, funct=0x20), imem_ready_i=1 -> one write addr 0x010 data 0x00221820, words_o=1.
- Push I (op=0x08, rs=1, rt=2, imm=0xFFFF) then J (op=0x02, target=0x0000100) back-to-back -> data 0x2022FFFF @ addr N, 0x08000100 @ N+1, consecutive cycles.
- imem_ready_i=0, push DEPTH words -> enc_ready_o=0; fifth valid held; release ready -> all DEPTH+1 words written in order, addresses contiguous.
- base_addr 2^ADDR_W-1, push 2 words -> addresses 0x3FF then 0x000 (ADDR_W=10).
- With ENC_OPCHECK_EN: R push with enc_op_i=0x3F -> data top 6 bits 0; fmt=3 push -> no write, err_o=1 until reset; without macro, err_o stays 0 and fmt=3 writes J-packed word.
- Assert rst_n low with 3 words buffered -> imem_wr_en_o=0, imem_addr_o=0, words_o=0 immediately; no stale writes after release.
